// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between host logic and the ALU command sequencer.
// The host drives commands and response acceptance; the sequencer answers.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_load;
  logic             clr_req;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_load, clr_req, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_load, clr_req, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives a fixed-latency accumulator ALU: one command in flight, operands held for the ALU
// latency, result captured and returned on a valid/ready response with an error flag.
module alu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int OP_W    = 4,
  parameter int ALU_LAT = 2,
  parameter int MAX_OP  = 13,
  parameter int DIV_OP  = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OP_W-1:0]     alu_opcode,
  output logic                alu_load,
  output logic                alu_rst,
  input  logic [WIDTH-1:0]    alu_result,
  output logic                busy,
  output logic [15:0]         op_count
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             cmd_err;

  function automatic logic is_err(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] b);
    return (int'(op) > MAX_OP) || ((int'(op) == DIV_OP) && (b == '0));
  endfunction

  assign accept  = bus.cmd_valid & bus.cmd_ready;
  assign cmd_err = is_err(bus.cmd_opcode, bus.cmd_b);
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A command always beats a simultaneous clear request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = cmd_err ? RESP : ISSUE;
        end else if (bus.clr_req && bus.cmd_ready) begin
          state_d = CLEAR;
          cnt_d   = CNT_INIT;
        end
      end
      CLEAR: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU pins are loaded on the accept edge so the ISSUE cycle already presents the new
  // operands; the result is then sampled ALU_LAT+1 edges after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_opcode    <= '0;
      alu_load      <= 1'b0;
      alu_rst       <= 1'b1;
      op_count      <= '0;
    end else begin
      bus.cmd_ready <= (state_d == IDLE);
      bus.rsp_valid <= (state_d == RESP);
      alu_rst       <= (state_d == CLEAR);
      if (state_q == IDLE && accept) begin
        if (cmd_err) begin
          bus.rsp_data <= '0;
          bus.rsp_err  <= 1'b1;
        end else begin
          alu_a      <= bus.cmd_a;
          alu_b      <= bus.cmd_b;
          alu_opcode <= bus.cmd_opcode;
          alu_load   <= bus.cmd_load;
        end
      end
      if (state_q == ISSUE) begin
        op_count <= op_count + 16'd1;
      end
      if (state_q == WAIT && cnt_q == '0) begin
        bus.rsp_data <= alu_result;
        bus.rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed commands against a small two-stage accumulator ALU
// model, with a queue-based scoreboard checked by an independent response monitor.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_a, alu_b, alu_result, op_count;
  logic [3:0]  alu_opcode;
  logic        alu_load, alu_rst, busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(16), .OP_W(4)) bus ();

  alu_cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_opcode(alu_opcode),
    .alu_load  (alu_load),
    .alu_rst   (alu_rst),
    .alu_result(alu_result),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Accumulator ALU: operand register stage, then accumulator with load-select A-mux.
  logic [15:0] ra, rb, acc;
  logic [3:0]  rop;
  logic        rl;

  function automatic logic [15:0] alu_f(input logic [15:0] a, b, input logic [3:0] op);
    case (op)
      4'd1:    return a & b;
      4'd3:    return a | b;
      4'd8:    return (b != 0) ? a / b : 16'h0;
      4'd9:    return a + b;
      default: return b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_rst) begin
      ra <= 0; rb <= 0; rop <= 0; rl <= 0; acc <= 0;
    end else begin
      ra <= alu_a; rb <= alu_b; rop <= alu_opcode; rl <= alu_load;
      acc <= alu_f(rl ? ra : acc, rb, rop);
    end
  end
  assign alu_result = acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", bus.rsp_data, e.d);
        check("rsp_err", bus.rsp_err, e.e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic ld, input logic clr, input logic push,
                      input logic [15:0] ed, input logic ee);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_load   = ld;
    bus.clr_req    = clr;
    if (push) exp_q.push_back({ed, ee});
    tick();
    bus.cmd_valid = 1'b0;
    bus.clr_req   = 1'b0;
  endtask

  // Returns the number of edges from the accept edge up to and including the handshake edge.
  task automatic wait_rsp(output int n);
    logic hs = 1'b0;
    n = 0;
    while (!hs && n < 50) begin
      hs = bus.rsp_valid & bus.rsp_ready;
      tick();
      n++;
    end
    if (!hs) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_opcode = 0; bus.cmd_a = 0; bus.cmd_b = 0;
    bus.cmd_load = 0; bus.clr_req = 0; bus.rsp_ready = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_alu_pins", {alu_a, alu_b}, 0);
    check("rst_alu_op_load", {alu_opcode, alu_load}, 0);
    check("rst_alu_rst", alu_rst, 1);
    check("rst_op_count", op_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_alu_rst", alu_rst, 0);

    // ADD with load: pins and latency
    send(4'd9, 16'h000C, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h000F, 1'b0);
    check("add_alu_a", alu_a, 16'h000C);
    check("add_alu_b", alu_b, 16'h0003);
    check("add_alu_op", alu_opcode, 9);
    check("add_alu_load", alu_load, 1);
    check("add_busy", busy, 1);
    check("add_cmd_ready", bus.cmd_ready, 0);
    wait_rsp(n);
    check("add_latency", n, 4);
    check("add_op_count", op_count, 1);
    check("add_back_idle", bus.cmd_ready, 1);

    // AND then OR-accumulate (A operand ignored when load=0)
    send(4'd1, 16'h000C, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
    wait_rsp(n);
    send(4'd3, 16'hFFFF, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0);
    wait_rsp(n);
    check("or_alu_load", alu_load, 0);
    check("or_op_count", op_count, 3);

    // Rejected commands leave the ALU pins and op_count alone
    send(4'd8, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
    check("div0_rsp_valid", bus.rsp_valid, 1);
    wait_rsp(n);
    check("div0_alu_a", alu_a, 16'hFFFF);
    check("div0_alu_b", alu_b, 16'h0005);
    check("div0_alu_op", alu_opcode, 3);
    check("div0_alu_load", alu_load, 0);
    check("div0_op_count", op_count, 3);
    send(4'd14, 16'h0001, 16'h0007, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
    wait_rsp(n);
    check("ill_op_count", op_count, 3);
    check("ill_alu_op", alu_opcode, 3);
    // Highest legal opcode and a divide with nonzero divisor are accepted
    send(4'd13, 16'h0000, 16'h00AA, 1'b1, 1'b0, 1'b1, 16'h00AA, 1'b0);
    wait_rsp(n);
    send(4'd8, 16'h0064, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0014, 1'b0);
    wait_rsp(n);
    check("div_op_count", op_count, 5);

    // Backpressure: response held, second command refused
    bus.rsp_ready = 1'b0;
    send(4'd9, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_rsp_seen", bus.rsp_valid, 1);
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_opcode = 4'd9; bus.cmd_a = 16'h7; bus.cmd_b = 16'h7;
      tick();
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_data", bus.rsp_data, 16'h0003);
      check("bp_cmd_ready", bus.cmd_ready, 0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_rsp(n);
    tick();
    check("bp_op_count", op_count, 6);

    // Reset while waiting on the ALU discards the response
    send(4'd9, 16'h0002, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    check("wait_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_alu_rst", alu_rst, 1);
    check("abort_op_count", op_count, 0);
    rst = 1'b0;
    repeat (6) tick();
    check("abort_no_rsp", bus.rsp_valid, 0);
    check("abort_ready", bus.cmd_ready, 1);

    // Clear request in IDLE: two cycles of ALU reset
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    check("clr1_alu_rst", alu_rst, 1);
    check("clr1_cmd_ready", bus.cmd_ready, 0);
    check("clr1_busy", busy, 1);
    tick();
    check("clr2_alu_rst", alu_rst, 1);
    check("clr2_cmd_ready", bus.cmd_ready, 0);
    tick();
    check("clr3_alu_rst", alu_rst, 0);
    check("clr3_cmd_ready", bus.cmd_ready, 1);
    check("clr3_busy", busy, 0);

    // Clear request coinciding with an accept: the command wins
    send(4'd9, 16'h0003, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h0007, 1'b0);
    check("clrcmd_alu_rst", alu_rst, 0);
    check("clrcmd_busy", busy, 1);
    tick();
    check("clrcmd_alu_rst2", alu_rst, 0);
    wait_rsp(n);
    check("clrcmd_op_count", op_count, 1);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
